// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared types and constants for the I2C EEPROM sequencer, controller and slave model
package eeprom_pkg;
    localparam int EE_AW = 11;
    localparam int EE_DW = 8;
    localparam logic [3:0] DEV_TYPE = 4'b1010;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_SETUP, RD_REQ, DONE} state_t;
endpackage

// File: rtl/eeprom_test_seq_if.sv
// eeprom_test_seq_if: request/address/ack handshake between the sequencer and the EEPROM controller
interface eeprom_test_seq_if import eeprom_pkg::*; #(parameter int AW = EE_AW);
    logic WR;
    logic RD;
    logic [AW-1:0] ADDR;
    logic ACK;
    modport master (output WR, RD, ADDR, input ACK);
    modport slave (input WR, RD, ADDR, output ACK);
endinterface

// File: rtl/eeprom_test_seq_cycle_timer.sv
// eeprom_test_seq_cycle_timer: counts up while enabled and flags expiry after N cycles out of load
module eeprom_test_seq_cycle_timer #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expired
);
    localparam int W = $clog2(N + 1);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(N - 1);
    always_ff @(posedge clk)
        if (rst || load) cnt <= '0;
        else if (count && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/eeprom_test_seq.sv
// eeprom_test_seq: writes a seed+i pattern block to the EEPROM controller and optionally reads it back,
// counting mismatches and aborting any request whose ACK does not arrive in time.
module eeprom_test_seq import eeprom_pkg::*; #(
    parameter int AW = EE_AW,
    parameter int DW = EE_DW,
    parameter int GAP_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [8:0]    len,
    input  logic [DW-1:0] seed,
    input  logic          verify_en,
    eeprom_test_seq_if.master bus,
    inout  wire  [DW-1:0] DATA,
    output logic          busy,
    output logic          done,
    output logic [8:0]    err_cnt,
    output logic          timeout
);
    state_t state;
    logic [AW-1:0] base, cur_addr, nxt_addr;
    logic [DW-1:0] pat_seed, wdata, cur_data, nxt_data;
    logic [8:0] cnt_len, idx, nxt;
    logic verify, drive, gap_done, to_exp;
    assign nxt = idx + 9'd1;
    assign cur_addr = base + AW'(idx);
    assign nxt_addr = base + AW'(nxt);
    assign cur_data = pat_seed + DW'(idx);
    assign nxt_data = pat_seed + DW'(nxt);
    assign DATA = drive ? wdata : 'z;
    // Both timers sit cleared outside their state, so every entry starts a fresh count
    eeprom_test_seq_cycle_timer #(.N(GAP_CYCLES)) gap_timer (
        .clk(CLK), .rst(RESET), .load(state != WR_GAP), .count(1'b1), .expired(gap_done)
    );
    eeprom_test_seq_cycle_timer #(.N(TIMEOUT_CYCLES)) ack_timer (
        .clk(CLK), .rst(RESET), .load(state != WR_REQ && state != RD_REQ), .count(1'b1), .expired(to_exp)
    );
    always_ff @(posedge CLK)
        if (RESET) begin
            state <= IDLE;
            bus.WR <= 1'b0;
            bus.RD <= 1'b0;
            bus.ADDR <= '0;
            drive <= 1'b0;
            wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err_cnt <= '0;
            timeout <= 1'b0;
            idx <= '0;
            base <= '0;
            cnt_len <= '0;
            pat_seed <= '0;
            verify <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base <= base_addr;
                    cnt_len <= len;
                    pat_seed <= seed;
                    verify <= verify_en;
                    idx <= '0;
                    err_cnt <= '0;
                    timeout <= 1'b0;
                    busy <= 1'b1;
                    bus.ADDR <= base_addr;
                    wdata <= seed;
                    bus.WR <= len != 9'd0;
                    drive <= len != 9'd0;
                    state <= len != 9'd0 ? WR_REQ : DONE;
                end
                // ACK wins over a watchdog expiring on the same edge
                WR_REQ: if (bus.ACK || to_exp) begin
                    bus.WR <= 1'b0;
                    drive <= 1'b0;
                    timeout <= !bus.ACK;
                    state <= bus.ACK ? WR_GAP : DONE;
                end
                WR_GAP: if (gap_done) begin
                    idx <= nxt == cnt_len ? 9'd0 : nxt;
                    bus.WR <= nxt != cnt_len;
                    drive <= nxt != cnt_len;
                    bus.ADDR <= nxt_addr;
                    wdata <= nxt_data;
                    state <= nxt != cnt_len ? WR_REQ : verify ? RD_SETUP : DONE;
                end
                RD_SETUP: begin
                    bus.RD <= 1'b1;
                    bus.ADDR <= cur_addr;
                    state <= RD_REQ;
                end
                RD_REQ: if (bus.ACK) begin
                    bus.RD <= 1'b0;
                    idx <= nxt;
                    if (DATA != cur_data && err_cnt != 9'd256) err_cnt <= err_cnt + 9'd1;
                    state <= nxt == cnt_len ? DONE : RD_SETUP;
                end else if (to_exp) begin
                    bus.RD <= 1'b0;
                    timeout <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_eeprom_test_seq.sv
// tb_eeprom_test_seq: directed bench with a behavioural EEPROM responder and a bus monitor
module tb_eeprom_test_seq;
    logic clk = 0, rst = 1, start = 0, verify_en = 0;
    logic [10:0] base_addr = 0;
    logic [8:0] len = 0;
    logic [7:0] seed = 0;
    wire [7:0] DATA;
    logic busy, done, timeout;
    logic [8:0] err_cnt;
    int tests = 0, fails = 0;

    eeprom_test_seq_if bus();
    eeprom_test_seq #(.GAP_CYCLES(8)) dut (
        .CLK(clk), .RESET(rst), .start(start), .base_addr(base_addr), .len(len), .seed(seed),
        .verify_en(verify_en), .bus(bus), .DATA(DATA), .busy(busy), .done(done),
        .err_cnt(err_cnt), .timeout(timeout)
    );
    always #5 clk = ~clk;

    // Responder: memory-backed slave, ACK after ack_delay+1 negedges, optional withheld address and corrupt byte
    logic [7:0] mem [0:2047];
    logic [11:0] corrupt_addr = 12'hFFF, hold_addr = 12'hFFF;
    int ack_delay = 1, req_cyc = 0;
    logic [7:0] sl_data;
    assign sl_data = mem[bus.ADDR] ^ ({1'b0, bus.ADDR} == corrupt_addr ? 8'hFF : 8'h00);
    assign DATA = bus.RD ? sl_data : 8'hzz;
    always @(negedge clk) begin
        if (rst || bus.ACK) begin
            bus.ACK = 1'b0;
            req_cyc = 0;
        end else if (bus.WR || bus.RD) begin
            if (req_cyc == ack_delay && !(bus.WR && {1'b0, bus.ADDR} == hold_addr)) begin
                bus.ACK = 1'b1;
                if (bus.WR) mem[bus.ADDR] = DATA;
            end
            req_cyc++;
        end else req_cyc = 0;
    end

    // Monitor: monotonic counters; tests compare deltas
    int nwr = 0, nrd = 0, ndone = 0, viol = 0, wr_hi = 0, wr_len = 0;
    logic pwr = 0, prd = 0;
    logic [10:0] wr_addr [0:63];
    logic [10:0] rd_addr [0:63];
    logic [7:0] wr_data [0:63];
    always @(negedge clk) begin
        if (bus.WR && !pwr) begin wr_addr[nwr % 64] = bus.ADDR; wr_data[nwr % 64] = DATA; nwr++; end
        if (bus.RD && !prd) begin rd_addr[nrd % 64] = bus.ADDR; nrd++; end
        if (done) ndone++;
        if ((bus.WR && bus.RD) || (bus.RD && DATA !== sl_data)) viol++;
        if (bus.WR) wr_hi++;
        else if (wr_hi != 0) begin wr_len = wr_hi; wr_hi = 0; end
        pwr = bus.WR;
        prd = bus.RD;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [10:0] b, input logic [8:0] l, input logic [7:0] s, input logic v);
        base_addr = b; len = l; seed = s; verify_en = v; start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done && cyc < max) begin tick(1); cyc++; end
    endtask

    task automatic test_reset;
        rst = 1;
        tick(2);
        tests++; if ({bus.WR, bus.RD} !== 2'b00) begin fails++; $display("FAIL reset_wr_rd: got %b want 00", {bus.WR, bus.RD}); end
        tests++; if (bus.ADDR !== 11'h000) begin fails++; $display("FAIL reset_addr: got %h want 000", bus.ADDR); end
        tests++; if ({busy, done, timeout} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, timeout}); end
        tests++; if (err_cnt !== 9'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        rst = 0;
        tick(1);
    endtask

    task automatic test_write_only;
        int w0, r0, d0, v0, cyc;
        w0 = nwr; r0 = nrd; d0 = ndone; v0 = viol;
        pulse_start(11'h010, 9'd4, 8'h30, 1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wo_busy: got %b want 1", busy); end
        wait_done(500, cyc);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL wo_done: got %b want 1 after %0d cycles", done, cyc); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wo_busy_low: got %b want 0", busy); end
        tick(3);
        tests++; if (nwr - w0 != 4 || nrd - r0 != 0) begin fails++; $display("FAIL wo_counts: got wr %0d rd %0d want 4 0", nwr - w0, nrd - r0); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (wr_addr[(w0 + i) % 64] !== 11'(16 + i)) begin fails++; $display("FAIL wo_addr%0d: got %h want %h", i, wr_addr[(w0 + i) % 64], 11'(16 + i)); end
            tests++; if (wr_data[(w0 + i) % 64] !== 8'(8'h30 + i)) begin fails++; $display("FAIL wo_data%0d: got %h want %h", i, wr_data[(w0 + i) % 64], 8'(8'h30 + i)); end
        end
        tests++; if (ndone - d0 != 1) begin fails++; $display("FAIL wo_done_cnt: got %0d want 1", ndone - d0); end
        tests++; if (err_cnt !== 9'd0 || timeout !== 1'b0) begin fails++; $display("FAIL wo_err: got err %0d to %b want 0 0", err_cnt, timeout); end
        tests++; if (viol - v0 != 0) begin fails++; $display("FAIL wo_bus: got %0d violations want 0", viol - v0); end
    endtask

    task automatic test_verify;
        int w0, r0, d0, v0, cyc;
        w0 = nwr; r0 = nrd; d0 = ndone; v0 = viol;
        pulse_start(11'h010, 9'd4, 8'h30, 1'b1);
        wait_done(500, cyc);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL vf_done: got %b want 1 after %0d cycles", done, cyc); end
        tick(3);
        tests++; if (nwr - w0 != 4 || nrd - r0 != 4) begin fails++; $display("FAIL vf_counts: got wr %0d rd %0d want 4 4", nwr - w0, nrd - r0); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_addr[(r0 + i) % 64] !== 11'(16 + i)) begin fails++; $display("FAIL vf_raddr%0d: got %h want %h", i, rd_addr[(r0 + i) % 64], 11'(16 + i)); end
        end
        tests++; if (err_cnt !== 9'd0) begin fails++; $display("FAIL vf_err: got %0d want 0", err_cnt); end
        tests++; if (viol - v0 != 0) begin fails++; $display("FAIL vf_bus: got %0d violations want 0 (DATA not released during RD)", viol - v0); end
        tests++; if (ndone - d0 != 1) begin fails++; $display("FAIL vf_done_cnt: got %0d want 1", ndone - d0); end
    endtask

    task automatic test_wrap;
        int w0, r0, cyc;
        w0 = nwr; r0 = nrd;
        corrupt_addr = 12'h000;
        pulse_start(11'h7FE, 9'd3, 8'hC0, 1'b1);
        wait_done(500, cyc);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL wr_done: got %b want 1 after %0d cycles", done, cyc); end
        tests++; if (nwr - w0 != 3 || nrd - r0 != 3) begin fails++; $display("FAIL wr_counts: got wr %0d rd %0d want 3 3", nwr - w0, nrd - r0); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (wr_addr[(w0 + i) % 64] !== 11'(2046 + i) || rd_addr[(r0 + i) % 64] !== 11'(2046 + i)) begin
                fails++; $display("FAIL wrap_addr%0d: got wr %h rd %h want %h", i, wr_addr[(w0 + i) % 64], rd_addr[(r0 + i) % 64], 11'(2046 + i));
            end
        end
        tests++; if (err_cnt !== 9'd1) begin fails++; $display("FAIL wrap_err: got %0d want 1", err_cnt); end
        corrupt_addr = 12'hFFF;
        tick(2);
    endtask

    task automatic test_timeout;
        int w0, r0, d0, cyc;
        w0 = nwr; r0 = nrd; d0 = ndone;
        hold_addr = 12'h101;
        pulse_start(11'h100, 9'd4, 8'h00, 1'b0);
        wait_done(6000, cyc);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL to_done: got %b want 1 after %0d cycles", done, cyc); end
        tests++; if (timeout !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL to_flags: got to %b busy %b want 1 0", timeout, busy); end
        tests++; if (wr_len != 4096) begin fails++; $display("FAIL to_wr_len: got %0d want 4096", wr_len); end
        tick(30);
        tests++; if (nwr - w0 != 2 || nrd - r0 != 0 || bus.WR !== 1'b0) begin fails++; $display("FAIL to_requests: got wr %0d rd %0d WR %b want 2 0 0", nwr - w0, nrd - r0, bus.WR); end
        tests++; if (ndone - d0 != 1) begin fails++; $display("FAIL to_done_cnt: got %0d want 1", ndone - d0); end
        hold_addr = 12'hFFF;
    endtask

    task automatic test_len0;
        int w0, r0, cyc;
        w0 = nwr; r0 = nrd;
        pulse_start(11'h123, 9'd0, 8'h00, 1'b1);
        wait_done(2, cyc);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL len0_done: got %b want 1 within 2 cycles", done); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL len0_to_clear: got %b want 0", timeout); end
        tick(3);
        tests++; if (nwr - w0 != 0 || nrd - r0 != 0) begin fails++; $display("FAIL len0_requests: got wr %0d rd %0d want 0 0", nwr - w0, nrd - r0); end
    endtask

    task automatic test_start_busy;
        int w0, r0, d0, cyc;
        w0 = nwr; r0 = nrd; d0 = ndone;
        pulse_start(11'h200, 9'd2, 8'h40, 1'b0);
        tick(3);
        pulse_start(11'h300, 9'd3, 8'h90, 1'b1);
        wait_done(500, cyc);
        tick(3);
        tests++; if (nwr - w0 != 2 || nrd - r0 != 0) begin fails++; $display("FAIL sb_counts: got wr %0d rd %0d want 2 0", nwr - w0, nrd - r0); end
        tests++; if (wr_addr[w0 % 64] !== 11'h200 || wr_addr[(w0 + 1) % 64] !== 11'h201) begin
            fails++; $display("FAIL sb_addr: got %h %h want 200 201", wr_addr[w0 % 64], wr_addr[(w0 + 1) % 64]);
        end
        tests++; if (ndone - d0 != 1) begin fails++; $display("FAIL sb_done_cnt: got %0d want 1", ndone - d0); end
    endtask

    task automatic test_reset_mid;
        int w0, cyc;
        w0 = nwr;
        pulse_start(11'h050, 9'd4, 8'h11, 1'b0);
        for (cyc = 0; cyc < 100 && !(nwr - w0 == 1 && !bus.WR && busy); cyc++) tick(1);
        tests++; if (cyc >= 100) begin fails++; $display("FAIL rm_gap: got no gap within %0d cycles want gap", cyc); end
        rst = 1;
        tick(1);
        tests++; if ({bus.WR, bus.RD, busy, done, timeout} !== 5'b0 || bus.ADDR !== 11'h000 || err_cnt !== 9'd0) begin
            fails++; $display("FAIL rm_outputs: got WR %b RD %b ADDR %h busy %b done %b err %0d to %b want all 0", bus.WR, bus.RD, bus.ADDR, busy, done, err_cnt, timeout);
        end
        rst = 0;
        tick(20);
        tests++; if (nwr - w0 != 1 || busy !== 1'b0) begin fails++; $display("FAIL rm_after: got wr %0d busy %b want 1 0", nwr - w0, busy); end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_verify();
        test_wrap();
        test_timeout();
        test_len0();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eeprom_test_seq.md
Name: eeprom_test_seq

Overview:
- Upstream command sequencer for the I2C EEPROM read/write controller.
- Writes a block of pattern bytes to the EEPROM: one WR request per byte, with a programmable write-cycle gap between requests.
- Optionally reads the same block back with RD requests and compares each byte against the regenerated pattern.
- Reports busy, a done pulse, a mismatch count and a timeout flag to the test/board top level.

Parameters:
- AW, 11: EEPROM byte-address width; addresses wrap modulo 2^AW.
- DW, 8: data width.
- GAP_CYCLES, 10000: idle CLK cycles after each write ACK, covering the EEPROM internal write time; minimum 1.
- TIMEOUT_CYCLES, 4096: maximum CLK cycles to wait for ACK on any single request.

Ports:
- CLK  in  1  system clock; the controller derives SCL as CLK/2.
- RESET  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle start request; sampled only in IDLE.
- base_addr  in  AW  first byte address; latched at start.
- len  in  9  byte count, 0..256; latched at start.
- seed  in  DW  pattern seed; byte i = seed + i (mod 2^DW); latched at start.
- verify_en  in  1  enables the readback phase; latched at start.
- WR  out  1  write request to controller.
- RD  out  1  read request to controller.
- ADDR  out  AW  byte address to controller.
- DATA  inout  DW  shared parallel data bus with controller.
- ACK  in  1  one-cycle completion pulse from controller.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of run, also on a timeout abort.
- err_cnt  out  9  number of readback mismatches in the current run.
- timeout  out  1  sticky; set on ACK timeout, cleared at next accepted start.

Behaviour:
- Reset values: WR=0, RD=0, ADDR=0, DATA released (Z), busy=0, done=0, err_cnt=0, timeout=0, state=IDLE. All outputs are registered.
- Handshake with the controller:
  - WR or RD is raised together with a stable ADDR, and DATA is driven for writes. All are held unchanged until the cycle ACK=1 is sampled.
  - WR/RD fall on the edge that samples ACK, so the controller sees them low when it returns to Idle. No back-to-back re-trigger is possible.
  - WR and RD are never high together.
- DATA bus ownership:
  - Driven only in WR_REQ.
  - Released (Z) in every other state, including one full cycle before any RD is raised.
  - Read data is sampled in the cycle ACK=1 while in RD_REQ.
- States:
  - IDLE: on start, latch inputs, clear err_cnt and timeout, set busy=1, idx=0. Next state is WR_REQ if len!=0, otherwise DONE.
  - WR_REQ: ADDR = base_addr+idx (mod 2^AW), DATA = seed+idx, WR=1. On ACK go to WR_GAP.
  - WR_GAP: count GAP_CYCLES. Then idx++. If idx==len: go to RD_SETUP (idx reset to 0) when verify_en, else DONE. Otherwise return to WR_REQ.
  - RD_SETUP: one cycle with bus released, then RD_REQ.
  - RD_REQ: ADDR = base_addr+idx, RD=1. On ACK, compare sampled DATA with seed+idx; a mismatch increments err_cnt, saturating at 256. Then idx++; go to DONE if idx==len, else RD_SETUP.
  - DONE: pulse done=1, set busy=0, return to IDLE.
- Timeout:
  - The watchdog restarts on entry to WR_REQ or RD_REQ.
  - If ACK has not arrived after TIMEOUT_CYCLES, drop WR/RD, set timeout=1, and go to DONE. The remaining bytes are skipped.
- ACK arriving outside WR_REQ/RD_REQ is ignored.
- start while busy is ignored.
- A write run whose addresses pass 2^AW-1 wraps to address 0; a read run wraps the same way.
- RESET mid-transfer returns to IDLE immediately with the reset values. The controller is reset by the same RESET, so no partial bus cycle survives.

Decomposition:
- Shared package eeprom_pkg holds:
  - the state enumeration (IDLE, WR_REQ, WR_GAP, RD_SETUP, RD_REQ, DONE);
  - EEPROM address width 11 and data width 8;
  - the I2C device-type nibble 4'b1010, shared with the controller and the bench slave model.
- One sub-module is natural: cycle_timer (load, count, expired), instantiated twice for the gap and timeout counters.

Test Plan:
- base_addr=0x010, len=4, seed=0x30, verify_en=0, with an ideal ACK responder: WR requests at 0x010..0x013 carrying data 0x30..0x33, no RD ever, one done pulse, err_cnt=0.
- Same run with verify_en=1 against an EEPROM slave model through the controller: 4 writes then 4 reads at 0x010..0x013, err_cnt=0. Check DATA is Z whenever RD=1.
- base_addr=0x7FE, len=3, verify_en=1, slave model forced to corrupt the byte at 0x000: addresses 0x7FE, 0x7FF, 0x000 are used, err_cnt=1.
- Responder withholds ACK on the second write: WR drops after exactly 4096 cycles, timeout=1, done pulses once, busy falls, and no further requests occur.
- len=0 -> done pulses within 2 cycles of start, no WR/RD activity. Also: start pulsed while busy is ignored, and RESET asserted during WR_GAP gives all outputs at reset values on the next edge.
